// File: rtl/fb_scanout_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fb_scanout_reader
// Purpose  : Raster scan-out of a 32x32-cell, 8-bit-per-cell framebuffer to
//            VGA 640x480@60 with a fixed 16-colour palette. Issues one RAM
//            read per pixel tick and aligns syncs/blank with the colour data.
// Revision : 1.0 - initial release
// ============================================================================
module fb_scanout_reader #(
  parameter logic [15:0] BASE_ADDR = 16'h200,
  parameter int          CELL_W    = 20,
  parameter int          CELL_H    = 15
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic [15:0] rd_addr,
  input  logic [7:0]  rd_data,
  output logic [9:0]  VGA_R,
  output logic [9:0]  VGA_G,
  output logic [9:0]  VGA_B,
  output logic        VGA_CLK,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK,
  output logic        VGA_SYNC,
  output logic        vblank,
  output logic        frame_start
);

  // Visible area is 32 cells in each direction; porches/sync widths are fixed.
  localparam int H_VIS = 32 * CELL_W;
  localparam int V_VIS = 32 * CELL_H;

  localparam logic [9:0] H_VIS_W    = 10'(H_VIS);
  localparam logic [9:0] H_VIS_LAST = 10'(H_VIS - 1);
  localparam logic [9:0] H_SYNC_BEG = 10'(H_VIS + 16);
  localparam logic [9:0] H_SYNC_END = 10'(H_VIS + 112);
  localparam logic [9:0] H_LAST     = 10'(H_VIS + 159);
  localparam logic [9:0] V_VIS_W    = 10'(V_VIS);
  localparam logic [9:0] V_VIS_LAST = 10'(V_VIS - 1);
  localparam logic [9:0] V_SYNC_BEG = 10'(V_VIS + 10);
  localparam logic [9:0] V_SYNC_END = 10'(V_VIS + 12);
  localparam logic [9:0] V_LAST     = 10'(V_VIS + 44);
  localparam logic [7:0] SUBC_LAST  = 8'(CELL_W - 1);
  localparam logic [7:0] SUBR_LAST  = 8'(CELL_H - 1);

  logic       pix_en_q, pix_en_d;
  logic       vga_clk_q, vga_clk_d;
  logic [9:0] h_q, h_d, v_q, v_d;
  logic [4:0] col_q, col_d, row_q, row_d;
  logic [7:0] subcol_q, subcol_d, subrow_q, subrow_d;
  logic [15:0] rd_addr_q, rd_addr_d;
  logic       vis1_q, vis1_d, hs1_q, hs1_d, vs1_q, vs1_d;
  logic       vis2_q, vis2_d, hs2_q, hs2_d, vs2_q, vs2_d;
  logic [9:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic       vblank_q, vblank_d;
  logic       frame_start_q, frame_start_d;
  logic       vis_now, hs_now, vs_now;
  logic [23:0] rgb24;
  logic [3:0] rd_data_unused;

  assign rd_data_unused = rd_data[7:4];

  function automatic logic [23:0] palette(input logic [3:0] idx);
    case (idx)
      4'h0: palette = 24'h000000;
      4'h1: palette = 24'hFFFFFF;
      4'h2: palette = 24'h880000;
      4'h3: palette = 24'hAAFFEE;
      4'h4: palette = 24'hCC44CC;
      4'h5: palette = 24'h00CC55;
      4'h6: palette = 24'h0000AA;
      4'h7: palette = 24'hEEEE77;
      4'h8: palette = 24'hDD8855;
      4'h9: palette = 24'h664400;
      4'hA: palette = 24'hFF7777;
      4'hB: palette = 24'h333333;
      4'hC: palette = 24'h777777;
      4'hD: palette = 24'hAAFF66;
      4'hE: palette = 24'h0088FF;
      4'hF: palette = 24'hBBBBBB;
      default: palette = 24'h000000;
    endcase
  endfunction

  // Next-state logic: raster counters, cell walk, read address and the
  // two-stage pipeline that lines syncs/blank up with the returned colour.
  always_comb begin
    pix_en_d      = ~pix_en_q;
    vga_clk_d     = pix_en_q;
    h_d           = h_q;
    v_d           = v_q;
    col_d         = col_q;
    row_d         = row_q;
    subcol_d      = subcol_q;
    subrow_d      = subrow_q;
    rd_addr_d     = rd_addr_q;
    vis1_d        = vis1_q;
    hs1_d         = hs1_q;
    vs1_d         = vs1_q;
    vis2_d        = vis2_q;
    hs2_d         = hs2_q;
    vs2_d         = vs2_q;
    r_d           = r_q;
    g_d           = g_q;
    b_d           = b_q;
    vis_now       = (h_q < H_VIS_W) && (v_q < V_VIS_W);
    hs_now        = !((h_q >= H_SYNC_BEG) && (h_q < H_SYNC_END));
    vs_now        = !((v_q >= V_SYNC_BEG) && (v_q < V_SYNC_END));
    rgb24         = palette(rd_data[3:0]);
    frame_start_d = pix_en_q && (h_q == 10'd0) && (v_q == 10'd0);

    if (pix_en_q) begin
      if (h_q == H_LAST) begin
        h_d      = 10'd0;
        col_d    = 5'd0;
        subcol_d = 8'd0;
        if (v_q == V_LAST) begin
          v_d      = 10'd0;
          row_d    = 5'd0;
          subrow_d = 8'd0;
        end else begin
          v_d = v_q + 10'd1;
          // Row only advances between visible lines; it holds through vblank.
          if (v_q < V_VIS_LAST) begin
            if (subrow_q == SUBR_LAST) begin
              subrow_d = 8'd0;
              row_d    = row_q + 5'd1;
            end else begin
              subrow_d = subrow_q + 8'd1;
            end
          end
        end
      end else begin
        h_d = h_q + 10'd1;
        // Column holds at the last visible pixel and through the porches.
        if ((v_q < V_VIS_W) && (h_q < H_VIS_LAST)) begin
          if (subcol_q == SUBC_LAST) begin
            subcol_d = 8'd0;
            col_d    = col_q + 5'd1;
          end else begin
            subcol_d = subcol_q + 8'd1;
          end
        end
      end

      if (vis_now) begin
        rd_addr_d = BASE_ADDR + {6'd0, row_q, col_q};
      end
      vis1_d = vis_now;
      hs1_d  = hs_now;
      vs1_d  = vs_now;

      vis2_d = vis1_q;
      hs2_d  = hs1_q;
      vs2_d  = vs1_q;
      r_d    = vis1_q ? {rgb24[23:16], rgb24[23:22]} : 10'd0;
      g_d    = vis1_q ? {rgb24[15:8],  rgb24[15:14]} : 10'd0;
      b_d    = vis1_q ? {rgb24[7:0],   rgb24[7:6]}   : 10'd0;
    end

    vblank_d = (v_d >= V_VIS_W);
  end

  // State registers; reset puts the raster at (0,0) with outputs idle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pix_en_q      <= 1'b0;
      vga_clk_q     <= 1'b1;
      h_q           <= 10'd0;
      v_q           <= 10'd0;
      col_q         <= 5'd0;
      row_q         <= 5'd0;
      subcol_q      <= 8'd0;
      subrow_q      <= 8'd0;
      rd_addr_q     <= BASE_ADDR;
      vis1_q        <= 1'b0;
      hs1_q         <= 1'b1;
      vs1_q         <= 1'b1;
      vis2_q        <= 1'b0;
      hs2_q         <= 1'b1;
      vs2_q         <= 1'b1;
      r_q           <= 10'd0;
      g_q           <= 10'd0;
      b_q           <= 10'd0;
      vblank_q      <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      pix_en_q      <= pix_en_d;
      vga_clk_q     <= vga_clk_d;
      h_q           <= h_d;
      v_q           <= v_d;
      col_q         <= col_d;
      row_q         <= row_d;
      subcol_q      <= subcol_d;
      subrow_q      <= subrow_d;
      rd_addr_q     <= rd_addr_d;
      vis1_q        <= vis1_d;
      hs1_q         <= hs1_d;
      vs1_q         <= vs1_d;
      vis2_q        <= vis2_d;
      hs2_q         <= hs2_d;
      vs2_q         <= vs2_d;
      r_q           <= r_d;
      g_q           <= g_d;
      b_q           <= b_d;
      vblank_q      <= vblank_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign rd_addr     = rd_addr_q;
  assign VGA_R       = r_q;
  assign VGA_G       = g_q;
  assign VGA_B       = b_q;
  assign VGA_CLK     = vga_clk_q;
  assign VGA_HS      = hs2_q;
  assign VGA_VS      = vs2_q;
  assign VGA_BLANK   = vis2_q;
  assign VGA_SYNC    = 1'b0;
  assign vblank      = vblank_q;
  assign frame_start = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_fb_scanout_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_fb_scanout_reader
// Purpose  : Self-checking bench. A full-size instance checks the address
//            walk, palette and latency; a 1x1-cell instance runs whole frames.
//            Both are compared every clock against an arithmetic raster model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fb_scanout_reader;

  localparam logic [15:0] BASE = 16'h200;

  logic clock = 1'b0;
  logic reset_n;

  logic [15:0] rd_addr_b, rd_addr_s;
  logic [7:0]  rd_data_b, rd_data_s;
  logic [9:0]  r_b, g_b, b_b, r_s, g_s, b_s;
  logic        clk_b, hs_b, vs_b, blank_b, sync_b, vblank_b, fs_b;
  logic        clk_s, hs_s, vs_s, blank_s, sync_s, vblank_s, fs_s;

  logic [7:0] mem [0:1023];
  longint     cyc;
  bit         chk_on;
  int         n_checks = 0;
  int         n_pass   = 0;

  typedef struct { logic [3:0] idx; logic [29:0] rgb; } pal_vec_t;
  typedef struct { int h; int v; bit is_addr; logic [29:0] exp; } probe_t;

  pal_vec_t pal_tab [16];
  probe_t   run1 [$];
  probe_t   run2 [$];

  always #10 clock = ~clock;

  fb_scanout_reader u_big (
    .clock(clock), .reset_n(reset_n), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
    .VGA_R(r_b), .VGA_G(g_b), .VGA_B(b_b), .VGA_CLK(clk_b), .VGA_HS(hs_b),
    .VGA_VS(vs_b), .VGA_BLANK(blank_b), .VGA_SYNC(sync_b), .vblank(vblank_b),
    .frame_start(fs_b)
  );

  fb_scanout_reader #(.BASE_ADDR(16'h200), .CELL_W(1), .CELL_H(1)) u_small (
    .clock(clock), .reset_n(reset_n), .rd_addr(rd_addr_s), .rd_data(rd_data_s),
    .VGA_R(r_s), .VGA_G(g_s), .VGA_B(b_s), .VGA_CLK(clk_s), .VGA_HS(hs_s),
    .VGA_VS(vs_s), .VGA_BLANK(blank_s), .VGA_SYNC(sync_s), .vblank(vblank_s),
    .frame_start(fs_s)
  );

  // Clocks since reset release.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  // Synchronous RAMs: data one clock after the address.
  always @(posedge clock) begin
    rd_data_b <= mem[10'(rd_addr_b - BASE)];
    rd_data_s <= mem[10'(rd_addr_s - BASE)];
  end

  function automatic logic [23:0] pal24(input int idx);
    case (idx)
      0: return 24'h000000;   1: return 24'hFFFFFF;
      2: return 24'h880000;   3: return 24'hAAFFEE;
      4: return 24'hCC44CC;   5: return 24'h00CC55;
      6: return 24'h0000AA;   7: return 24'hEEEE77;
      8: return 24'hDD8855;   9: return 24'h664400;
      10: return 24'hFF7777;  11: return 24'h333333;
      12: return 24'h777777;  13: return 24'hAAFF66;
      14: return 24'h0088FF;  default: return 24'hBBBBBB;
    endcase
  endfunction

  function automatic logic [9:0] widen(input int x);
    return 10'(x * 4 + x / 64);
  endfunction

  function automatic logic [29:0] pal_wide(input logic [7:0] d);
    logic [23:0] p;
    p = pal24(int'(d) % 16);
    return {widen(int'(p[23:16])), widen(int'(p[15:8])), widen(int'(p[7:0]))};
  endfunction

  // Expected output vector after c clocks since release, from raster arithmetic:
  // pixel n-2 on the colour/sync outputs, address of the last visible pixel
  // up to n-1, vblank from the current line.
  function automatic logic [52:0] model_out(input longint c, input int cw, input int chh);
    int hv, vv, ht, vt, h, v;
    longint fr, n;
    logic [15:0] addr;
    logic [29:0] rgb;
    logic vis, hs, vs, vb, fs, vc;
    hv = 32 * cw; vv = 32 * chh; ht = hv + 160; vt = vv + 45;
    fr = longint'(ht) * vt;
    n = c / 2;
    addr = BASE; rgb = '0; vis = 1'b0; hs = 1'b1; vs = 1'b1;
    if (n >= 2) begin
      h = int'((n - 2) % ht);
      v = int'(((n - 2) / ht) % vt);
      vis = (h < hv) && (v < vv);
      hs = !((h >= hv + 16) && (h < hv + 112));
      vs = !((v >= vv + 10) && (v < vv + 12));
      if (vis) rgb = pal_wide(mem[(v / chh) * 32 + h / cw]);
    end
    if (n >= 1) begin
      h = int'((n - 1) % ht);
      v = int'(((n - 1) / ht) % vt);
      if (v >= vv) begin h = hv - 1; v = vv - 1; end
      else if (h >= hv) h = hv - 1;
      addr = BASE + 16'((v / chh) * 32 + h / cw);
    end
    v  = int'((n / ht) % vt);
    vb = (v >= vv);
    fs = (c >= 2) && (c % 2 == 0) && (((n - 1) % fr) == 0);
    vc = (c % 2 == 0);
    return {addr, rgb, hs, vs, vis, 1'b0, vc, vb, fs};
  endfunction

  task automatic check(input string name, input logic [52:0] act, input logic [52:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at clk %0d: got %h, want %h", name, cyc, act, exp);
  endtask

  // Every clock, both instances against the model.
  always @(negedge clock) begin
    if (chk_on) begin
      check("big_stream", {rd_addr_b, r_b, g_b, b_b, hs_b, vs_b, blank_b, sync_b, clk_b, vblank_b, fs_b},
            model_out(cyc, 20, 15));
      check("small_stream", {rd_addr_s, r_s, g_s, b_s, hs_s, vs_s, blank_s, sync_s, clk_s, vblank_s, fs_s},
            model_out(cyc, 1, 1));
    end
  end

  task automatic run_probes(input probe_t tab [$], input string tag);
    longint tgt;
    foreach (tab[i]) begin
      tgt = 2 * (longint'(tab[i].v) * 800 + tab[i].h + (tab[i].is_addr ? 1 : 2));
      while (cyc < tgt) @(negedge clock);
      if (tab[i].is_addr)
        check($sformatf("%s%0d_addr(h%0d,v%0d)", tag, i, tab[i].h, tab[i].v),
              53'(rd_addr_b), 53'(tab[i].exp[15:0]));
      else
        check($sformatf("%s%0d_rgb(h%0d,v%0d)", tag, i, tab[i].h, tab[i].v),
              53'({r_b, g_b, b_b}), 53'(tab[i].exp));
    end
  endtask

  initial begin
    pal_tab[0]  = '{4'h2, {10'h222, 10'h000, 10'h000}};
    pal_tab[1]  = '{4'h1, {10'h3FF, 10'h3FF, 10'h3FF}};
    pal_tab[2]  = '{4'h0, {10'h000, 10'h000, 10'h000}};
    pal_tab[3]  = '{4'h3, {10'h2AA, 10'h3FF, 10'h3BB}};
    pal_tab[4]  = '{4'h4, {10'h333, 10'h111, 10'h333}};
    pal_tab[5]  = '{4'h5, {10'h000, 10'h333, 10'h155}};
    pal_tab[6]  = '{4'h6, {10'h000, 10'h000, 10'h2AA}};
    pal_tab[7]  = '{4'h7, {10'h3BB, 10'h3BB, 10'h1DD}};
    pal_tab[8]  = '{4'h8, {10'h377, 10'h222, 10'h155}};
    pal_tab[9]  = '{4'h9, {10'h199, 10'h111, 10'h000}};
    pal_tab[10] = '{4'hA, {10'h3FF, 10'h1DD, 10'h1DD}};
    pal_tab[11] = '{4'hB, {10'h0CC, 10'h0CC, 10'h0CC}};
    pal_tab[12] = '{4'hC, {10'h1DD, 10'h1DD, 10'h1DD}};
    pal_tab[13] = '{4'hD, {10'h2AA, 10'h3FF, 10'h199}};
    pal_tab[14] = '{4'hE, {10'h000, 10'h222, 10'h3FF}};
    pal_tab[15] = '{4'hF, {10'h2EE, 10'h2EE, 10'h2EE}};

    // Random framebuffer; cells 0..15 of row 0 carry the palette table
    // (cell 0 = 0x02, cell 1 = 0x51, the rest with random upper nibbles).
    for (int a = 0; a < 1024; a++) mem[a] = 8'($urandom);
    mem[0] = 8'h02;
    mem[1] = 8'h51;
    for (int i = 2; i < 16; i++) mem[i] = {4'($urandom), pal_tab[i].idx};

    run1.push_back('{0,   0, 1'b1, 30'h200});
    run1.push_back('{10,  0, 1'b0, pal_tab[0].rgb});
    run1.push_back('{19,  0, 1'b1, 30'h200});
    run1.push_back('{19,  0, 1'b0, pal_tab[0].rgb});
    run1.push_back('{20,  0, 1'b1, 30'h201});
    run1.push_back('{20,  0, 1'b0, pal_tab[1].rgb});
    for (int i = 1; i < 16; i++) run1.push_back('{20 * i + 10, 0, 1'b0, pal_tab[i].rgb});
    run1.push_back('{639, 0, 1'b1, 30'h21F});
    run1.push_back('{640, 0, 1'b0, 30'h0});
    run1.push_back('{700, 0, 1'b1, 30'h21F});

    run2.push_back('{700, 0,  1'b1, 30'h21F});
    run2.push_back('{0,   1,  1'b1, 30'h200});
    run2.push_back('{25,  1,  1'b1, 30'h201});
    run2.push_back('{639, 14, 1'b1, 30'h21F});
    run2.push_back('{0,   15, 1'b1, 30'h220});
    run2.push_back('{39,  15, 1'b1, 30'h221});
    run2.push_back('{40,  15, 1'b1, 30'h222});
    run2.push_back('{639, 15, 1'b1, 30'h23F});
    run2.push_back('{799, 15, 1'b1, 30'h23F});

    chk_on  = 1'b0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clock);
    chk_on = 1'b1;
    @(negedge clock);
    reset_n = 1'b1;

    // Line 0: palette, latency and address walk.
    run_probes(run1, "p1_");

    // Asynchronous reset in the middle of line 1 (h=300), no clock edge.
    while (cyc < 2200) @(negedge clock);
    @(posedge clock);
    #3 reset_n = 1'b0;
    #1;
    check("async_reset_big", {rd_addr_b, r_b, g_b, b_b, hs_b, vs_b, blank_b, sync_b, clk_b, vblank_b, fs_b},
          53'({BASE, 30'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}));
    check("async_reset_small", {rd_addr_s, r_s, g_s, b_s, hs_s, vs_s, blank_s, sync_s, clk_s, vblank_s, fs_s},
          53'({BASE, 30'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}));
    repeat (3) @(negedge clock);
    reset_n = 1'b1;

    // First HS fall after release is pixel 656 of line 0.
    @(negedge clock);
    while (hs_b !== 1'b0 && cyc < 3000) @(negedge clock);
    check("hs_first_fall_clk", 53'(cyc), 53'd1316);

    run_probes(run2, "p2_");

    // Small instance: second frame_start exactly one frame after the first.
    while (fs_s !== 1'b1 && cyc < 31000) @(negedge clock);
    check("small_frame_period_clk", 53'(cyc), 53'd29570);

    repeat (100) @(negedge clock);
    @(posedge clock);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
